bin_enc_iter: RTL and testbench
===============================

# bin_enc_iter

Iterative binary encoder: the inverse of the one-hot/binary decoder. It accepts a request vector of IN_W bits and emits the binary index of every active bit, one index per output beat, in ascending bit order. Both sides use valid/ready handshakes. It sits behind request collectors such as interrupt-pending and wakeup vectors, and feeds per-index consumers that were previously driven by `bin_dec` select lines.

## Interface
- IN_W, 8, number of request bits; must be ≥ 2.
- OUT_W, $clog2(IN_W), index width; derived, never overridden.
- ACT, `High, active level of the request bits (`High or `Low).

- clk  in  1  clock; all state updates on the rising edge.
- reset_  in  1  asynchronous, active-low reset.
- in_valid  in  1  request vector valid.
- in_ready  out  1  block is idle and can accept a vector.
- in  in  IN_W  request vector.
- out_valid  out  1  index beat valid.
- out_ready  in  1  consumer accepts the beat.
- out  out  OUT_W  binary index of the current active bit.
- out_last  out  1  current beat is the final index of the vector.
- busy  out  1  a vector is being serialised.

## Operation
- Normalisation: req = (ACT == `High) ? in : ~in.
- States:
  - IDLE: in_ready=1.
  - SCAN: in_ready=0, busy=1.
- IDLE, in_valid & nonzero req: load req into the `pend` register; go to SCAN.
- IDLE, in_valid & req==0: the handshake completes, nothing is emitted, and the state stays IDLE.
- SCAN outputs:
  - out_valid=1.
  - out = index of the lowest set bit of `pend`.
  - out_last = (`pend` has exactly one bit set).
- SCAN, out_valid & out_ready: clear that bit in `pend`. If out_last was set, go to IDLE.
- SCAN, out_ready low: `pend`, out and out_last hold stable; no beat is dropped or repeated.
- No combinational path from in, in_valid or out_ready to any output. in_ready depends on state only. out and out_last are decoded from `pend` only.
- Reset value of every output: in_ready=1, out_valid=0, out=0, out_last=0, busy=0. `pend` is cleared and the state is IDLE.
- Reset mid-SCAN clears `pend` asynchronously and drops out_valid immediately. The partially emitted vector is abandoned.

## Timing
- Vector accepted at edge N -> first beat valid in cycle N+1.
- A vector with k active bits under continuous out_ready gives k consecutive beats, in cycles N+1 … N+k.
- in_ready rises in cycle N+k+1 (a one-cycle bubble). The next vector can be accepted at the end of cycle N+k+1.
- Throughput: k+1 cycles per vector; all-zero vectors take 1 cycle.
- Simultaneous in_valid and final out handshake: the new vector is not accepted in that cycle, because in_ready is low in SCAN.

## Configuration
- BIN_ENC_ITER_MSB_FIRST_EN:
  - Defined: scan order is descending. out is the highest set bit of `pend`, and out_last marks the lowest index.
  - Undefined: ascending order, as described above.
- Handshake, latency and reset behaviour are identical in both builds.

## Structure
- Shared package `bin_enc_pkg`:
  - state enum typedef `bin_enc_state_t` {IDLE, SCAN};
  - function `onehot_cnt_is1` (single-bit detect), reused by other encoders.
- ACT values come from the existing `High/`Low definitions.
- One sub-module, `pri_enc`:
  - combinational priority encoder, parameters IN_W and direction;
  - outputs the index of the lowest (or highest) set bit plus a zero flag.
- Instantiated once on `pend`; the FSM, `pend` register and handshake logic live in `bin_enc_iter`.

## Test plan
- IN_W=8, ACT=`High, in=8'b1010_0101, out_ready=1 -> out = 0,2,5,7 in four consecutive cycles; out_last only with 7; in_ready high again one cycle later.
- in=8'h00 with in_valid -> accepted in one cycle, out_valid never asserts, busy stays 0.
- in=8'h90, out_ready low for 3 cycles then high -> out=4 held stable for 4 cycles, then out=7 with out_last.
- ACT=`Low, in=8'hFE -> single beat out=0 with out_last=1.
- in=8'hFF, reset_ pulled low after the third beat -> out_valid=0 and in_ready=1 immediately; after release, a new vector 8'h02 gives out=1 with out_last.
- BIN_ENC_ITER_MSB_FIRST_EN defined, in=8'b0100_1001 -> out = 6,3,0; out_last with 0.

Source files
------------

// File: rtl/bin_enc_pkg.sv
// Shared types and helpers for the binary encoders.
// Also provides the `High/`Low active-level macros when they are not already defined.
`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

package bin_enc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } bin_enc_state_t;

   // True when exactly one bit of v is set (v is non-zero and a power of two).
   function automatic logic onehot_cnt_is1(input logic [63:0] v);
      return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
   endfunction

endpackage

// File: rtl/bin_enc_iter_pri_enc.sv
// Combinational priority encoder: index of the lowest (or, with MSB_FIRST, highest) set bit.
// The zero flag is set and the index is 0 when no bit is set.
module pri_enc #(
   parameter  int IN_W      = 8,
   parameter  bit MSB_FIRST = 1'b0,
   localparam int OUT_W     = $clog2(IN_W)
) (
   input  logic [IN_W-1:0]  req_i,
   output logic [OUT_W-1:0] idx_o,
   output logic             zero_o
);

   always_comb begin
      idx_o  = '0;
      zero_o = (req_i == '0);
      if (MSB_FIRST) begin
         // Ascending sweep: the last hit is the highest set bit.
         for (int i = 0; i < IN_W; i++) begin
            if (req_i[i]) idx_o = OUT_W'(i);
         end
      end else begin
         for (int i = IN_W - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = OUT_W'(i);
         end
      end
   end

endmodule

// File: rtl/bin_enc_iter.sv
// Iterative binary encoder: serialises the index of every active request bit, one per beat.
// Define BIN_ENC_ITER_MSB_FIRST_EN to emit indices in descending instead of ascending order.
module bin_enc_iter
   import bin_enc_pkg::*;
#(
   parameter  int   IN_W  = 8,
   parameter  logic ACT   = `High,
   localparam int   OUT_W = $clog2(IN_W)
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out,
   output logic             out_last,
   output logic             busy
);

`ifdef BIN_ENC_ITER_MSB_FIRST_EN
   localparam bit MsbFirst = 1'b1;
`else
   localparam bit MsbFirst = 1'b0;
`endif

   bin_enc_state_t   state_q, state_d;
   logic [IN_W-1:0]  pend_q, pend_d;
   logic [IN_W-1:0]  req;
   logic [OUT_W-1:0] idx;
   logic             pend_zero;
   logic             last;

   assign req  = (ACT == `High) ? in : ~in;
   assign last = onehot_cnt_is1(64'(pend_q));

   pri_enc #(
      .IN_W      (IN_W),
      .MSB_FIRST (MsbFirst)
   ) u_pri_enc (
      .req_i  (pend_q),
      .idx_o  (idx),
      .zero_o (pend_zero)
   );

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q <= IDLE;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      unique case (state_q)
         IDLE: begin
            // An all-zero vector completes its handshake here and emits nothing.
            if (in_valid && (req != '0)) begin
               pend_d  = req;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (out_ready) begin
               pend_d = pend_q & ~(IN_W'(1) << idx);
               if (last) state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            pend_d  = '0;
         end
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == SCAN);
   assign out_valid = (state_q == SCAN) && !pend_zero;
   assign out       = idx;
   assign out_last  = last;

endmodule

// File: tb/tb_bin_enc_iter.sv
// Directed testbench for bin_enc_iter: ACT=`High instance plus an ACT=`Low instance.
// Expected orders follow BIN_ENC_ITER_MSB_FIRST_EN when it is defined.
module tb_bin_enc_iter;

   logic       clk = 1'b0;
   logic       reset_ = 1'b0;

   logic       in_valid = 1'b0;
   logic [7:0] in_vec = 8'h00;
   logic       out_ready = 1'b0;
   logic       in_ready, out_valid, out_last, busy;
   logic [2:0] out_idx;

   logic       lo_in_valid = 1'b0;
   logic [7:0] lo_in_vec = 8'hFF;
   logic       lo_out_ready = 1'b1;
   logic       lo_in_ready, lo_out_valid, lo_out_last, lo_busy;
   logic [2:0] lo_out_idx;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bin_enc_iter #(.IN_W(8), .ACT(`High)) dut (
      .clk       (clk),
      .reset_    (reset_),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out_idx),
      .out_last  (out_last),
      .busy      (busy)
   );

   bin_enc_iter #(.IN_W(8), .ACT(`Low)) dut_lo (
      .clk       (clk),
      .reset_    (reset_),
      .in_valid  (lo_in_valid),
      .in_ready  (lo_in_ready),
      .in        (lo_in_vec),
      .out_valid (lo_out_valid),
      .out_ready (lo_out_ready),
      .out       (lo_out_idx),
      .out_last  (lo_out_last),
      .busy      (lo_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Checks one output beat of the main instance.
   task automatic beat(input string tag, input int idx, input bit lst);
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
      check({tag, ".out"},   32'(out_idx),   32'(idx));
      check({tag, ".last"},  32'(out_last),  32'(lst));
      check({tag, ".ready"}, 32'(in_ready),  32'd0);
      $display("beat %s: out=%0d last=%0b (expect %0d/%0b)", tag, out_idx, out_last, idx, lst);
   endtask

   task automatic idle_chk(input string tag);
      check({tag, ".in_ready"},  32'(in_ready),  32'd1);
      check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
      check({tag, ".busy"},      32'(busy),      32'd0);
      $display("idle %s: in_ready=%0b out_valid=%0b busy=%0b", tag, in_ready, out_valid, busy);
   endtask

   initial begin
`ifdef BIN_ENC_ITER_MSB_FIRST_EN
      int ord_a5 [4] = '{7, 5, 2, 0};
      int ord_90 [2] = '{7, 4};
      int ord_ff [4] = '{7, 6, 5, 4};
      int ord_49 [3] = '{6, 3, 0};
`else
      int ord_a5 [4] = '{0, 2, 5, 7};
      int ord_90 [2] = '{4, 7};
      int ord_ff [4] = '{0, 1, 2, 3};
      int ord_49 [3] = '{0, 3, 6};
`endif

      // Reset values
      #2;
      idle_chk("rst");
      check("rst.out",  32'(out_idx),  32'd0);
      check("rst.last", 32'(out_last), 32'd0);
      step();
      reset_ = 1'b1;
      step();

      // 8'hA5 with continuous out_ready: four back-to-back beats, then one bubble
      in_vec = 8'hA5; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         beat($sformatf("a5[%0d]", i), ord_a5[i], i == 3);
         step();
      end
      idle_chk("a5.done");

      // All-zero vector: accepted in one cycle, nothing emitted
      in_vec = 8'h00; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      idle_chk("zero.c1");
      step();
      idle_chk("zero.c2");

      // 8'h90 with back-pressure: first beat held stable for four cycles
      in_vec = 8'h90; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         beat($sformatf("90.hold[%0d]", i), ord_90[0], 1'b0);
         step();
      end
      out_ready = 1'b1;
      beat("90.hold[3]", ord_90[0], 1'b0);
      step();
      beat("90.second", ord_90[1], 1'b1);
      step();
      idle_chk("90.done");

      // Active-low instance: 8'hFE normalises to a single request at bit 0
      check("lo.idle", 32'(lo_in_ready), 32'd1);
      lo_in_vec = 8'hFE; lo_in_valid = 1'b1;
      step();
      lo_in_valid = 1'b0;
      check("lo.valid", 32'(lo_out_valid), 32'd1);
      check("lo.out",   32'(lo_out_idx),   32'd0);
      check("lo.last",  32'(lo_out_last),  32'd1);
      $display("beat lo: out=%0d last=%0b (expect 0/1)", lo_out_idx, lo_out_last);
      step();
      check("lo.done", 32'(lo_in_ready), 32'd1);

      // 8'hFF abandoned by an asynchronous reset after the third beat
      in_vec = 8'hFF; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         beat($sformatf("ff[%0d]", i), ord_ff[i], 1'b0);
         step();
      end
      beat("ff[3]", ord_ff[3], 1'b0);
      #2;
      reset_ = 1'b0;
      #1;
      idle_chk("ff.rst");
      check("ff.rst.out", 32'(out_idx), 32'd0);
      step();
      reset_ = 1'b1;
      step();
      idle_chk("ff.post");

      // Fresh vector after reset: 8'h02 yields a single beat at index 1
      in_vec = 8'h02; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      beat("02", 1, 1'b1);
      step();
      idle_chk("02.done");

      // 8'h49: order depends on the scan direction of the build
      in_vec = 8'h49; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         beat($sformatf("49[%0d]", i), ord_49[i], i == 2);
         step();
      end
      idle_chk("49.done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, expected finish before 100000ns");
      $fatal(1, "timeout");
   end

endmodule
